// File: rtl/genius_pkg.sv
// genius_pkg: colour codes and conditioner state shared by the button front-end, controller and LED driver.
package genius_pkg;
    localparam int COLOR_CODEFY_W = 2;
    typedef enum logic [1:0] {GREEN = 2'd0, RED = 2'd1, BLUE = 2'd2, YELLOW = 2'd3} color_e;
    typedef enum logic {IDLE, WAIT_RELEASE} cond_state_e;
    function automatic color_e encode_color(input logic [3:0] level);
        return level[3] ? YELLOW : level[2] ? BLUE : level[1] ? RED : GREEN;
    endfunction
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchroniser plus stability counter for one raw push-button.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0] sync;
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level)
                cnt <= '0;
            else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/color_button_conditioner.sv
// color_button_conditioner: debounces the four colour buttons and turns one clean press into a single
// color_valid strobe, rejecting simultaneous presses and presses made while input is not accepted.
module color_button_conditioner #(
    parameter int COLOR_CODEFY_W  = genius_pkg::COLOR_CODEFY_W,
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      button_color_green,
    input  logic                      button_color_red,
    input  logic                      button_color_blue,
    input  logic                      button_color_yellow,
    input  logic                      accept_en,
    output logic                      color_valid,
    output logic [COLOR_CODEFY_W-1:0] color_code,
    output logic                      multi_press,
    output logic [3:0]                btn_level
);
    import genius_pkg::*;
    logic [3:0] raw;
    logic multi;
    cond_state_e state;
    assign raw = {button_color_yellow, button_color_blue, button_color_red, button_color_green};
    assign multi = (btn_level & (btn_level - 4'd1)) != 4'd0;
    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_deb
            button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
                .clk(clk), .rst(rst), .raw(raw[i]), .level(btn_level[i])
            );
        end
    endgenerate
    // Any press leaves IDLE, so a button held across accept_en rising is never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            color_valid <= 1'b0;
            multi_press <= 1'b0;
            color_code  <= '0;
        end else begin
            color_valid <= 1'b0;
            multi_press <= 1'b0;
            case (state)
                IDLE: if (|btn_level) begin
                    state <= WAIT_RELEASE;
                    if (accept_en) begin
                        if (multi)
                            multi_press <= 1'b1;
                        else begin
                            color_valid <= 1'b1;
                            color_code  <= COLOR_CODEFY_W'(encode_color(btn_level));
                        end
                    end
                end
                WAIT_RELEASE: if (btn_level == 4'd0) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_color_button_conditioner.sv
// tb_color_button_conditioner: table-driven press/release records plus directed reset, accept and hold sequences.
module tb_color_button_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic g, r, b, y, acc;
    logic cv, mp;
    logic [1:0] code;
    logic [3:0] lvl;
    int checks = 0;
    int fails = 0;
    int nv, nm, nl;
    logic prev_strobe = 1'b0;

    color_button_conditioner #(.DEBOUNCE_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .button_color_green(g), .button_color_red(r),
        .button_color_blue(b), .button_color_yellow(y),
        .accept_en(acc), .color_valid(cv), .color_code(code),
        .multi_press(mp), .btn_level(lvl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;
        logic       acc;
        int         press;
        int         exp_nv;
        int         exp_code;
        int         exp_nm;
        int         exp_nl;
    } vec_t;
    vec_t vt[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] btn, input logic a);
        {y, b, r, g} = btn;
        acc = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (cv === 1'b1) nv++;
        if (mp === 1'b1) nm++;
        if (lvl !== 4'd0) nl++;
    endtask

    task automatic run(input logic [3:0] btn, input logic a, input int n);
        drive(btn, a);
        repeat (n) tick();
    endtask

    task automatic clear_tally();
        nv = 0; nm = 0; nl = 0;
    endtask

    task automatic reset_press(input logic [3:0] btn, input int cycles, input int exp_code);
        drive(btn, 1'b1);
        rst = 1'b1;
        repeat (cycles) begin
            tick();
            check("reset_outputs", int'({cv, mp, lvl, code}), 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pre_strobe_quiet", int'(cv), 0);
        end
        tick();
        check("strobe_at_2plusN", int'(cv), 1);
        check("strobe_code", int'(code), exp_code);
    endtask

    always @(negedge clk) begin
        if (rst) prev_strobe = 1'b0;
        else begin
            check("strobe_rules", int'((cv & mp) | (prev_strobe & (cv | mp))), 0);
            prev_strobe = cv | mp;
        end
    end

    initial begin
        vt[0] = '{4'b0010, 1'b1, 3, 1, 1, 0, 3};
        vt[1] = '{4'b0100, 1'b1, 3, 1, 2, 0, 3};
        vt[2] = '{4'b0001, 1'b1, 1, 0, 2, 0, 0};
        vt[3] = '{4'b1010, 1'b1, 4, 0, 2, 1, 4};
        vt[4] = '{4'b1000, 1'b1, 3, 1, 3, 0, 3};
        vt[5] = '{4'b0100, 1'b0, 3, 0, 3, 0, 3};
        vt[6] = '{4'b0001, 1'b1, 2, 1, 0, 0, 2};

        clear_tally();
        reset_press(4'b0001, 3, 0);
        clear_tally();
        run(4'b0001, 1'b1, 5);
        run(4'b0000, 1'b1, 8);
        check("held_green_once", nv, 0);

        for (int k = 0; k < 7; k++) begin
            clear_tally();
            run(vt[k].btn, vt[k].acc, vt[k].press);
            run(4'b0000, vt[k].acc, 8);
            check($sformatf("vec%0d_valid_count", k), nv, vt[k].exp_nv);
            check($sformatf("vec%0d_code", k), int'(code), vt[k].exp_code);
            check($sformatf("vec%0d_multi_count", k), nm, vt[k].exp_nm);
            check($sformatf("vec%0d_level_cycles", k), nl, vt[k].exp_nl);
            check($sformatf("vec%0d_level_released", k), int'(lvl), 0);
        end

        clear_tally();
        run(4'b0100, 1'b0, 6);
        run(4'b0100, 1'b1, 6);
        check("held_through_enable_valid", nv, 0);
        check("held_through_enable_multi", nm, 0);
        run(4'b0000, 1'b1, 8);
        clear_tally();
        run(4'b0100, 1'b1, 3);
        run(4'b0000, 1'b1, 8);
        check("repress_after_enable_valid", nv, 1);
        check("repress_after_enable_code", int'(code), 2);

        clear_tally();
        run(4'b0001, 1'b1, 5);
        run(4'b0011, 1'b1, 5);
        run(4'b0001, 1'b1, 10);
        check("overlap_hold_valid", nv, 1);
        check("overlap_hold_code", int'(code), 0);
        check("overlap_hold_multi", nm, 0);
        run(4'b0000, 1'b1, 8);
        clear_tally();
        run(4'b0010, 1'b1, 3);
        run(4'b0000, 1'b1, 8);
        check("after_overlap_release_valid", nv, 1);
        check("after_overlap_release_code", int'(code), 1);

        run(4'b0010, 1'b1, 6);
        clear_tally();
        reset_press(4'b0010, 1, 1);
        run(4'b0000, 1'b1, 8);
        check("midpress_reset_single", nv, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
